// File: rtl/seq_det_sched_if.sv
// Bundle between the frame producers / bit-serial detector and the scheduler.
// The scheduler takes the slave view; the producer and detector side takes the master view.
interface seq_det_sched_if #(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 16,
    parameter int CNT_W   = 5
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]         req;
    logic [NREQ*FRAME_W-1:0] frame;
    logic [NREQ-1:0]         gnt;
    logic                    busy;
    logic                    done;
    logic [IDW-1:0]          done_id;
    logic [CNT_W-1:0]        match_cnt;
    logic                    det_clr;
    logic                    det_vld;
    logic                    det_din;
    logic                    det_hit;

    modport slave (
        input  req, frame, det_hit,
        output gnt, busy, done, done_id, match_cnt, det_clr, det_vld, det_din
    );

    modport master (
        output req, frame, det_hit,
        input  gnt, busy, done, done_id, match_cnt, det_clr, det_vld, det_din
    );
endinterface

// File: rtl/seq_det_sched.sv
// Round-robin scheduler feeding requester frames MSB-first into one shared
// "101" detector and returning the per-frame hit count tagged with the requester id.
module seq_det_sched #(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 16,
    parameter int CNT_W   = 5
) (
    input  logic           clk,
    input  logic           reset,
    seq_det_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BCW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [BCW-1:0]   BIT_LAST = BCW'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDW-1:0]   ID_LAST  = IDW'(NREQ - 1);

    logic [2:0]         r_state;
    logic [IDW-1:0]     r_last;
    logic [IDW-1:0]     r_id;
    logic [IDW-1:0]     r_done_id;
    logic [FRAME_W-1:0] r_shift;
    logic [BCW-1:0]     r_bitcnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               r_vld_q;
    logic [NREQ-1:0]    r_gnt;
    logic               r_busy;
    logic               r_done;
    logic               r_det_clr;
    logic               r_det_vld;
    logic               r_det_din;

    logic               w_any;
    logic               w_take;
    logic [IDW-1:0]     w_idx;
    logic [IDW-1:0]     w_win;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [FRAME_W-1:0] w_frames [NREQ];

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_frame_split
            assign w_frames[g] = bus.frame[g*FRAME_W +: FRAME_W];
        end
    endgenerate

    // Round-robin pick: first set request after the last winner, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_take = 1'b0;
        w_idx  = '0;
        w_win  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx  = IDW'((int'(r_last) + k) % NREQ);
            w_take = !w_any && bus.req[w_idx];
            w_win  = w_take ? w_idx : w_win;
            w_any  = w_any | bus.req[w_idx];
        end
    end

    // Hit counter next value; vld_q gates hits to the bits this frame presented.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_vld_q && bus.det_hit && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Hit counter and valid delay line; the counter restarts on every grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_vld_q <= r_det_vld;
            if ((r_state == ST_IDLE) && w_any) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    // Frame sequencing FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last      <= ID_LAST;
            r_id        <= '0;
            r_done_id   <= '0;
            r_match_cnt <= '0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_det_clr   <= 1'b0;
            r_det_vld   <= 1'b0;
            r_det_din   <= 1'b0;
        end else begin
            r_gnt     <= '0;
            r_det_clr <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state   <= ST_CLEAR;
                        r_gnt     <= NREQ'(1) << w_win;
                        r_shift   <= w_frames[w_win];
                        r_id      <= w_win;
                        r_last    <= w_win;
                        r_busy    <= 1'b1;
                        r_det_clr <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    // det_din is its own flop, so the shifter runs one bit ahead of it.
                    r_state   <= ST_SHIFT;
                    r_det_vld <= 1'b1;
                    r_det_din <= r_shift[FRAME_W-1];
                    r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                    r_bitcnt  <= '0;
                end
                ST_SHIFT: begin
                    if (r_bitcnt == BIT_LAST) begin
                        r_state   <= ST_DRAIN;
                        r_det_vld <= 1'b0;
                        r_det_din <= 1'b0;
                    end else begin
                        r_bitcnt  <= r_bitcnt + BCW'(1);
                        r_det_din <= r_shift[FRAME_W-1];
                        r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                    end
                end
                ST_DRAIN: begin
                    r_state     <= ST_DONE;
                    r_done      <= 1'b1;
                    r_done_id   <= r_id;
                    r_match_cnt <= w_cnt_next;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_det_vld <= 1'b0;
                    r_det_din <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.done_id   = r_done_id;
    assign bus.match_cnt = r_match_cnt;
    assign bus.det_clr   = r_det_clr;
    assign bus.det_vld   = r_det_vld;
    assign bus.det_din   = r_det_din;
endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched: a reference "101" Mealy detector answers det_hit,
// expected counts, ids and timing are hand-computed constants.
module tb_seq_det_sched;
    localparam int NREQ = 4;
    localparam int FW   = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    seq_det_sched_if #(.NREQ(NREQ), .FRAME_W(FW), .CNT_W(5)) bus_a ();
    seq_det_sched_if #(.NREQ(NREQ), .FRAME_W(FW), .CNT_W(2)) bus_b ();

    seq_det_sched #(.NREQ(NREQ), .FRAME_W(FW), .CNT_W(5)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    seq_det_sched #(.NREQ(NREQ), .FRAME_W(FW), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    // Reference detector step: returns {hit, next_state}; states 0=none, 1="1", 2="10".
    function automatic logic [2:0] ref_step(input logic [1:0] st, input logic din);
        case (st)
            2'd0:    ref_step = din ? {1'b0, 2'd1} : {1'b0, 2'd0};
            2'd1:    ref_step = din ? {1'b0, 2'd1} : {1'b0, 2'd2};
            2'd2:    ref_step = din ? {1'b1, 2'd1} : {1'b0, 2'd0};
            default: ref_step = {1'b0, 2'd0};
        endcase
    endfunction

    logic [1:0] ref_st_a, ref_st_b;

    // Reference detector behind DUT a.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_st_a <= 2'd0; bus_a.det_hit <= 1'b0;
        end else if (bus_a.det_clr) begin
            ref_st_a <= 2'd0; bus_a.det_hit <= 1'b0;
        end else if (bus_a.det_vld) begin
            {bus_a.det_hit, ref_st_a} <= ref_step(ref_st_a, bus_a.det_din);
        end else begin
            bus_a.det_hit <= 1'b0;
        end
    end

    // Reference detector behind DUT b.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_st_b <= 2'd0; bus_b.det_hit <= 1'b0;
        end else if (bus_b.det_clr) begin
            ref_st_b <= 2'd0; bus_b.det_hit <= 1'b0;
        end else if (bus_b.det_vld) begin
            {bus_b.det_hit, ref_st_b} <= ref_step(ref_st_b, bus_b.det_din);
        end else begin
            bus_b.det_hit <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One frame on DUT a from requester id, checking grant, bitstream, latency and result.
    task automatic run_frame(input int id, input logic [15:0] fr, input int exp_cnt);
        bit          got;
        int          lat, nb, gnt_extra, din_bad;
        logic [15:0] bits;
        bus_a.frame = '0;
        bus_a.frame[id*FW +: FW] = fr;
        bus_a.req = 4'(1) << id;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (bus_a.gnt != 4'd0) got = 1'b1;
        end
        check_eq("gnt", 64'(bus_a.gnt), 64'(4'(1) << id));
        check_eq("busy_clear", 64'(bus_a.busy), 64'd1);
        check_eq("det_clr", 64'(bus_a.det_clr), 64'd1);
        bus_a.req = 4'd0;
        bits = 16'd0; nb = 0; lat = 0; gnt_extra = 0; din_bad = 0; got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            lat++;
            if (bus_a.gnt != 4'd0) gnt_extra++;
            if (!bus_a.det_vld && bus_a.det_din) din_bad++;
            if (bus_a.det_vld) begin
                bits = {bits[14:0], bus_a.det_din};
                nb++;
            end
            if (bus_a.done) got = 1'b1;
        end
        check_eq("done_seen", 64'(got), 64'd1);
        check_eq("gnt_one_cycle", 64'(gnt_extra), 64'd0);
        check_eq("din_zero_idle", 64'(din_bad), 64'd0);
        check_eq("done_latency", 64'(lat), 64'd18);
        check_eq("nbits", 64'(nb), 64'd16);
        check_eq("bitstream", 64'(bits), 64'(fr));
        check_eq("done_id", 64'(bus_a.done_id), 64'(id));
        check_eq("match_cnt", 64'(bus_a.match_cnt), 64'(exp_cnt));
        @(negedge clk);
        check_eq("done_pulse", 64'(bus_a.done), 64'd0);
        check_eq("busy_idle", 64'(bus_a.busy), 64'd0);
        check_eq("cnt_held", 64'(bus_a.match_cnt), 64'(exp_cnt));
    endtask

    initial begin
        int exp_order[5];
        int gnt_t[5];
        int ng, nd, t, ndone;
        int done_ids[5];
        bit got;
        exp_order = '{0, 1, 2, 3, 0};
        bus_a.req = 4'd0; bus_a.frame = '0;
        bus_b.req = 4'd0; bus_b.frame = '0;
        reset = 1'b1;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_outs", 64'({bus_a.gnt, bus_a.busy, bus_a.done, bus_a.done_id,
                                    bus_a.match_cnt, bus_a.det_clr, bus_a.det_vld, bus_a.det_din}), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_frame(0, 16'hA5A5, 4);
        run_frame(1, 16'h5555, 7);
        run_frame(2, 16'hAAAA, 7);
        run_frame(3, 16'hFFFF, 0);
        run_frame(0, 16'h0000, 0);
        run_frame(1, 16'h0005, 1);
        run_frame(2, 16'h8000, 0);

        // Round-robin with every request held; restart so requester 0 leads.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus_a.frame = {16'h1234, 16'h5555, 16'hAAAA, 16'hA5A5};
        bus_a.req = 4'b1111;
        ng = 0; nd = 0;
        for (t = 1; t < 130 && ng < 5; t++) begin
            @(negedge clk);
            if (bus_a.gnt != 4'd0) begin
                check_eq("rr_gnt", 64'(bus_a.gnt), 64'(4'(1) << exp_order[ng]));
                gnt_t[ng] = t;
                ng++;
            end
            if (bus_a.done && nd < 5) begin
                done_ids[nd] = int'(bus_a.done_id);
                nd++;
            end
        end
        bus_a.req = 4'd0;
        check_eq("rr_ngrants", 64'(ng), 64'd5);
        for (int k = 1; k < 5; k++) begin
            if (k < ng) check_eq("rr_gap", 64'(gnt_t[k] - gnt_t[k-1]), 64'd20);
        end
        check_eq("rr_ndone", 64'(nd), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < nd) check_eq("rr_done_id", 64'(done_ids[k]), 64'(exp_order[k]));
        end
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (!bus_a.busy) got = 1'b1;
        end
        check_eq("rr_drain", 64'(got), 64'd1);
        @(negedge clk);

        // Abort a frame mid-shift with the asynchronous reset.
        bus_a.frame = {4{16'hFFFF}};
        bus_a.req = 4'b0001;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus_a.gnt != 4'd0) got = 1'b1;
        end
        check_eq("abort_gnt", 64'(bus_a.gnt), 64'd1);
        bus_a.req = 4'd0;
        repeat (5) @(negedge clk);
        check_eq("abort_in_shift", 64'(bus_a.det_vld), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_outs", 64'({bus_a.gnt, bus_a.busy, bus_a.done, bus_a.done_id,
                                    bus_a.match_cnt, bus_a.det_clr, bus_a.det_vld, bus_a.det_din}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus_a.done || bus_a.busy) ndone++;
        end
        check_eq("abort_no_done", 64'(ndone), 64'd0);
        run_frame(3, 16'h0A0A, 2);

        // Saturation on the 2-bit counter instance.
        bus_b.frame = '0;
        bus_b.frame[15:0] = 16'h5555;
        bus_b.req = 4'b0001;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus_b.gnt != 4'd0) got = 1'b1;
        end
        check_eq("sat_gnt", 64'(bus_b.gnt), 64'd1);
        bus_b.req = 4'd0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus_b.done) got = 1'b1;
        end
        check_eq("sat_done", 64'(got), 64'd1);
        check_eq("sat_cnt", 64'(bus_b.match_cnt), 64'd3);
        check_eq("sat_id", 64'(bus_b.done_id), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
